vga_sync_detector: RTL
======================

# vga_sync_detector

Receive-side counterpart to the VGA sync generator. Samples incoming active-low Hsync/Vsync on a pixel-rate clock enable, measures line and frame length, and locks when timing matches the 640x480@60 (800x525) mode. Once locked, it regenerates Hpos/Vpos and an active-area flag for capture or loopback checking. It sits between the VGA sync inputs (or the generator outputs, in loopback) and pixel capture/compare logic.

## Interface
- H_TOTAL, 800, pixels per line expected
- V_TOTAL, 525, lines per frame expected
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_SYNC_START, 704, column at which Hsync falls
- V_SYNC_START, 523, line at which Vsync falls
- LOCK_FRAMES, 2, consecutive matching frames required to lock (1..15)

- clk  in  1  100 MHz system clock; sole clock
- rst_n  in  1  reset, synchronous, active-low
- px_ce  in  1  one-clk pulse per pixel (25 MHz rate); all counting qualified by it
- hsync_in  in  1  Hsync, active-low, asynchronous to clk
- vsync_in  in  1  Vsync, active-low, asynchronous to clk
- hpos  out  12  recovered column, 0..H_TOTAL-1
- vpos  out  12  recovered line, 0..V_TOTAL-1
- active  out  1  locked & hpos<H_ACTIVE & vpos<V_ACTIVE
- locked  out  1  timing matches parameters
- frame_start  out  1  one-clk pulse on each Vsync fall sample
- err  out  1  one-clk pulse on loss of lock
- h_total_meas  out  12  last measured line length, px
- v_total_meas  out  12  last measured frame length, lines

## Operation
- Sync inputs: 2-flop synchronizer per input on every clk; flops reset to 1 (idle). Edge detect only on px_ce cycles: fall = prev_sample==1 & sample==0; prev_sample updates on px_ce only, reset to 1.
- hrun (12 b, saturates at 4095): on px_ce increments; on Hsync-fall sample, h_total_meas<=hrun, hrun<=1.
- vrun (12 b, saturating): +1 on each Hsync fall; on Vsync-fall sample, v_total_meas<=vrun (including that cycle's increment if Hsync also falls), vrun<=0.
- Line check at each Hsync fall: h_ok = (hrun==H_TOTAL). Frame flag h_bad set on any !h_ok and cleared on each Vsync fall after evaluation.
- hpos: Hsync-fall sample -> H_SYNC_START; otherwise on px_ce, wrap H_TOTAL-1->0, else +1. vpos: Vsync-fall sample -> V_SYNC_START; otherwise +1 on each hpos wrap, wrap V_TOTAL-1->0. Simultaneous Hsync and Vsync falls apply both loads.
- FSM, reset state SEARCH:
  - SEARCH: locked=0. Vsync fall -> MEASURE, match_cnt<=0, h_bad<=0. No compare on this fall.
  - MEASURE: on Vsync fall, frame_ok = (vrun_final==V_TOTAL) & !h_bad & !(current line !h_ok). frame_ok: match_cnt+1; reaching LOCK_FRAMES -> LOCKED, locked<=1. Otherwise match_cnt<=0, stay.
  - LOCKED: any !h_ok at Hsync fall, or !frame_ok at Vsync fall -> MEASURE, match_cnt<=0, locked<=0, err pulse.
  - Any state: hrun reaching 2*H_TOTAL without Hsync fall -> SEARCH, locked<=0; err pulse if leaving LOCKED.
- Recovered coordinates equal the generator's internal counters delayed by one pixel, i.e. aligned to the registered sync outputs.

## Timing
- Reset: hpos=0, vpos=0, active=0, locked=0, frame_start=0, err=0, h_total_meas=0, v_total_meas=0, FSM=SEARCH, hrun=0, vrun=0, match_cnt=0.
- Reset asserted mid-lock takes effect on the next clk edge regardless of px_ce.
- Input-to-decision latency: 2 clk synchronizer, then the next px_ce sample. All outputs are registered and update on the px_ce clk that sees the edge.
- frame_start, err: exactly one clk wide.
- locked rises on the clk of the LOCK_FRAMES-th compared Vsync fall (the 3rd Vsync fall after reset with default parameters). It falls on the same clk as err.
- px_ce gaps (irregular enable) stall all counters. No timeout accrues without px_ce.

## Test plan
- Reset: hold rst_n=0 with sync toggling -> all outputs 0, FSM SEARCH. Release -> no err.
- Clean 800x525 stream (Hsync low cols 704-799, Vsync low lines 523-524) -> h_total_meas=800, v_total_meas=525. locked=1 on the 3rd Vsync fall. frame_start pulses once per 420000 px_ce.
- Locked, then check positions -> hpos=704 on each Hsync-fall sample, vpos=523 at Vsync fall. active=1 exactly 640x480 px per frame.
- Locked, one line of 801 px -> err pulse and locked=0 at that Hsync fall. Relock after 2 further clean frames.
- Locked, hold Hsync high -> SEARCH after 1600 px_ce, one err pulse, locked=0.
- Locked, pulse rst_n low 1 clk between px_ce pulses -> next clk all outputs 0. Relock after 3 Vsync falls.

Source files
------------

// File: rtl/vga_sync_if.sv
// vga_sync_if: sync inputs and recovered timing outputs; master drives syncs, slave is the detector
interface vga_sync_if;
  logic        px_ce;
  logic        hsync_in;
  logic        vsync_in;
  logic [11:0] hpos;
  logic [11:0] vpos;
  logic        active;
  logic        locked;
  logic        frame_start;
  logic        err;
  logic [11:0] h_total_meas;
  logic [11:0] v_total_meas;
  modport master (
    output px_ce, hsync_in, vsync_in,
    input  hpos, vpos, active, locked, frame_start, err, h_total_meas, v_total_meas
  );
  modport slave (
    input  px_ce, hsync_in, vsync_in,
    output hpos, vpos, active, locked, frame_start, err, h_total_meas, v_total_meas
  );
endinterface

// File: rtl/vga_sync_detector.sv
// vga_sync_detector: measures incoming Hsync/Vsync timing, locks to the expected mode and regenerates hpos/vpos/active
// Ports: clk, rst_n (synchronous, active-low); bus (slave): px_ce, hsync_in, vsync_in in;
//        hpos, vpos, active, locked, frame_start, err, h_total_meas, v_total_meas out
module vga_sync_detector #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int H_SYNC_START = 704,
  parameter int V_SYNC_START = 523,
  parameter int LOCK_FRAMES  = 2
) (
  input logic      clk,
  input logic      rst_n,
  vga_sync_if.slave bus
);
  localparam logic [11:0] HT  = 12'(H_TOTAL);
  localparam logic [11:0] VT  = 12'(V_TOTAL);
  localparam logic [11:0] HA  = 12'(H_ACTIVE);
  localparam logic [11:0] VA  = 12'(V_ACTIVE);
  localparam logic [11:0] HSS = 12'(H_SYNC_START);
  localparam logic [11:0] VSS = 12'(V_SYNC_START);
  localparam logic [11:0] TMO = 12'(2 * H_TOTAL);
  localparam logic [3:0]  LF  = 4'(LOCK_FRAMES);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t      state_q;
  logic [1:0]  hs_q, vs_q;
  logic        hs_prev_q, vs_prev_q;
  logic [11:0] hrun_q, hrun_d, hrun_inc, vrun_q, vrun_d, vrun_inc;
  logic [11:0] hpos_q, hpos_d, vpos_q, vpos_d, hmeas_q, vmeas_q;
  logic [3:0]  match_q;
  logic        h_bad_q, h_bad_d, locked_q, fs_q, err_q;
  logic        h_fall, v_fall, line_bad, frame_ok, h_wrap, timeout;
  always_comb begin
    h_fall   = bus.px_ce & hs_prev_q & ~hs_q[1];
    v_fall   = bus.px_ce & vs_prev_q & ~vs_q[1];
    hrun_inc = (&hrun_q) ? hrun_q : hrun_q + 12'd1;
    hrun_d   = !bus.px_ce ? hrun_q : h_fall ? 12'd1 : hrun_inc;
    // fires once, on the pixel where the run since the last Hsync fall reaches two lines
    timeout  = bus.px_ce & ~h_fall & !(&hrun_q) & (hrun_inc == TMO);
    line_bad = h_fall & (hrun_q != HT);
    vrun_inc = (h_fall & !(&vrun_q)) ? vrun_q + 12'd1 : vrun_q;
    vrun_d   = v_fall ? 12'd0 : vrun_inc;
    frame_ok = (vrun_inc == VT) & ~h_bad_q & ~line_bad;
    h_bad_d  = v_fall ? 1'b0 : h_bad_q | line_bad;
    h_wrap   = bus.px_ce & ~h_fall & (hpos_q == HT - 12'd1);
    hpos_d   = h_fall ? HSS : !bus.px_ce ? hpos_q : h_wrap ? 12'd0 : hpos_q + 12'd1;
    vpos_d   = v_fall ? VSS : !h_wrap ? vpos_q : (vpos_q == VT - 12'd1) ? 12'd0 : vpos_q + 12'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      hs_q      <= 2'b11;
      vs_q      <= 2'b11;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      hrun_q    <= '0;
      vrun_q    <= '0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      hmeas_q   <= '0;
      vmeas_q   <= '0;
      match_q   <= '0;
      h_bad_q   <= 1'b0;
      locked_q  <= 1'b0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      hs_q    <= {hs_q[0], bus.hsync_in};
      vs_q    <= {vs_q[0], bus.vsync_in};
      if (bus.px_ce) begin
        hs_prev_q <= hs_q[1];
        vs_prev_q <= vs_q[1];
      end
      hrun_q  <= hrun_d;
      vrun_q  <= vrun_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      h_bad_q <= h_bad_d;
      if (h_fall) hmeas_q <= hrun_q;
      if (v_fall) vmeas_q <= vrun_inc;
      fs_q    <= v_fall;
      err_q   <= 1'b0;
      if (timeout) begin
        state_q  <= SEARCH;
        locked_q <= 1'b0;
        err_q    <= state_q == LOCKED;
      end else begin
        case (state_q)
          SEARCH: if (v_fall) begin
            state_q <= MEASURE;
            match_q <= '0;
          end
          MEASURE: if (v_fall) begin
            match_q <= frame_ok ? match_q + 4'd1 : 4'd0;
            if (frame_ok && (match_q + 4'd1 == LF)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: if (line_bad || (v_fall && !frame_ok)) begin
            state_q  <= MEASURE;
            match_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end
  assign bus.hpos         = hpos_q;
  assign bus.vpos         = vpos_q;
  assign bus.active       = locked_q & (hpos_q < HA) & (vpos_q < VA);
  assign bus.locked       = locked_q;
  assign bus.frame_start  = fs_q;
  assign bus.err          = err_q;
  assign bus.h_total_meas = hmeas_q;
  assign bus.v_total_meas = vmeas_q;
endmodule
